// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and encodings for the PC generator
package pc_gen_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_TGT  = 2'b01;
  localparam logic [1:0] PCSRC_TRAP = 2'b10;
  localparam logic [1:0] PCSRC_RET  = 2'b11;
endpackage

// File: rtl/pc_gen_unit_incrementer.sv
// pc_incrementer: sequential PC adder, pc_plus = pc + (half ? 2 : 4), modulo 2^XLEN
//   in  pc [XLEN], half (16-bit instruction); out pc_plus [XLEN]
module pc_incrementer #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            half,
  output logic [XLEN-1:0] pc_plus
);
  assign pc_plus = pc + (half ? XLEN'(2) : XLEN'(4));
endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: architectural PC register with next-PC select, stall, halt/resume and misaligned-redirect trap
//   in  clk, rst (async, active-high), stall, pc_src[2], target[XLEN], epc[XLEN], is_compressed, halt_req, resume
//   out pc[XLEN], pc_plus[XLEN] (comb), pc_valid, misalign (1-cycle pulse), bad_addr[XLEN]
//   RVC_EN: when defined, 16-bit instructions supported (increment 2/4, alignment on bit 0 only)
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] target,
  input  logic [XLEN-1:0] epc,
  input  logic            is_compressed,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);
  state_t          state, state_n;
  logic            half, bad, go;
  logic [XLEN-1:0] sel;
`ifdef RVC_EN
  assign half = is_compressed;
  assign bad  = (pc_src == PCSRC_TGT || pc_src == PCSRC_RET) && sel[0];
`else
  logic unused_compressed;
  assign unused_compressed = is_compressed;
  assign half = 1'b0;
  assign bad  = (pc_src == PCSRC_TGT || pc_src == PCSRC_RET) && (sel[1:0] != 2'b00);
`endif
  pc_incrementer #(.XLEN(XLEN)) u_inc (
    .pc     (pc),
    .half   (half),
    .pc_plus(pc_plus)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= BOOT;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      BOOT:    state_n = RUN;
      RUN:     state_n = halt_req ? HALTED : RUN;
      HALTED:  state_n = resume ? RUN : HALTED;
      default: state_n = BOOT;
    endcase
  end
  // a PC update happens only in RUN with no halt request and no stall
  always_comb begin
    sel = pc_src == PCSRC_SEQ  ? pc_plus :
          pc_src == PCSRC_TGT  ? target  :
          pc_src == PCSRC_TRAP ? TRAP_VEC : epc;
    go  = state == RUN && !halt_req && !stall;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc       <= RESET_VEC;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
      bad_addr <= '0;
    end else begin
      pc       <= go ? (bad ? TRAP_VEC : sel) : pc;
      pc_valid <= state_n == RUN;
      misalign <= go && bad;
      bad_addr <= (go && bad) ? sel : bad_addr;
    end
endmodule
